// File: rtl/dvi_tx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dvi_tx_pkg : link FSM state encoding and TMDS control tokens          |
// | Revision   : 1.0                                                      |
// +----------------------------------------------------------------------+
package dvi_tx_pkg;

  typedef enum logic [2:0] {
    LOCK_WAIT  = 3'd0,
    SERDES_RST = 3'd1,
    FLUSH      = 3'd2,
    ALIGN      = 3'd3,
    ACTIVE     = 3'd4
  } link_state_t;

  localparam logic [9:0] TMDS_CTRL_C0 = 10'b1101010100;
  localparam logic [9:0] TMDS_CTRL_C1 = 10'b0010101011;
  localparam logic [9:0] TMDS_CTRL_C2 = 10'b0101010100;
  localparam logic [9:0] TMDS_CTRL_C3 = 10'b1010101011;

  localparam int unsigned LINK_CNT_W   = 16;
  localparam logic [7:0]  LOSS_CNT_MAX = 8'hFF;

endpackage
`default_nettype wire

// File: rtl/dvi_tx_sync_2ff.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dvi_tx_sync_2ff : two-flop synchronizer into the pixel_clock domain   |
// | Revision        : 1.0                                                 |
// +----------------------------------------------------------------------+
module dvi_tx_sync_2ff (
  input  logic pixel_clock,
  input  logic reset_n,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule
`default_nettype wire

// File: rtl/dvi_tx_link_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dvi_tx_link_ctrl : DVI transmit link bring-up, lane gating and        |
// |                    lock-loss supervision                              |
// | Revision         : 1.0                                                |
// +----------------------------------------------------------------------+
module dvi_tx_link_ctrl
  import dvi_tx_pkg::*;
#(
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned SERDES_RST_CYCLES  = 16,
  parameter int unsigned FLUSH_CYCLES       = 64
) (
  input  logic       pixel_clock,
  input  logic       reset_n,
  input  logic       mmcm_locked,
  input  logic       link_enable,
  input  logic       enc_vsync,
  input  logic [9:0] enc_ch0,
  input  logic [9:0] enc_ch1,
  input  logic [9:0] enc_ch2,
  output logic [9:0] lane_ch0,
  output logic [9:0] lane_ch1,
  output logic [9:0] lane_ch2,
  output logic       phy_reset,
  output logic       link_up,
  output logic [7:0] lock_loss_cnt
);

  localparam logic [LINK_CNT_W-1:0] c_lock_last  = LINK_CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [LINK_CNT_W-1:0] c_rst_last   = LINK_CNT_W'(SERDES_RST_CYCLES - 1);
  localparam logic [LINK_CNT_W-1:0] c_flush_last = LINK_CNT_W'(FLUSH_CYCLES - 1);

  link_state_t           r_state;
  link_state_t           w_next_state;
  logic [LINK_CNT_W-1:0] r_cnt;
  logic [LINK_CNT_W-1:0] w_cnt_next;
  logic                  w_locked_s;
  logic                  w_loss_evt;
  logic                  r_vsync_d;
  logic                  w_phy_reset_d;
  logic                  w_link_up_d;
  logic [9:0]            r_lane_ch0;
  logic [9:0]            r_lane_ch1;
  logic [9:0]            r_lane_ch2;
  logic                  r_phy_reset;
  logic                  r_link_up;
  logic [7:0]            r_loss_cnt;

  dvi_tx_sync_2ff u_lock_sync (
    .pixel_clock (pixel_clock),
    .reset_n     (reset_n),
    .i_async     (mmcm_locked),
    .o_sync      (w_locked_s)
  );

  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= LOCK_WAIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_cnt_next   = r_cnt + 1'b1;
    w_loss_evt   = 1'b0;
    case (r_state)
      LOCK_WAIT: begin
        if (w_locked_s && link_enable) begin
          if (r_cnt == c_lock_last) w_next_state = SERDES_RST;
        end else begin
          w_cnt_next = '0;
        end
      end
      SERDES_RST: if (r_cnt == c_rst_last)   w_next_state = FLUSH;
      FLUSH:      if (r_cnt == c_flush_last) w_next_state = ALIGN;
      ALIGN: begin
        w_cnt_next = r_cnt;
        if (enc_vsync && !r_vsync_d) w_next_state = ACTIVE;
      end
      ACTIVE:  w_cnt_next = r_cnt;
      default: w_next_state = LOCK_WAIT;
    endcase
    // Lock loss wins over a disable so a coincident event is still counted.
    if (r_state != LOCK_WAIT && (!w_locked_s || !link_enable)) begin
      w_next_state = LOCK_WAIT;
      w_loss_evt   = !w_locked_s;
    end
    if (w_next_state != r_state) w_cnt_next = '0;
  end

  always_comb begin
    w_phy_reset_d = (w_next_state == LOCK_WAIT) || (w_next_state == SERDES_RST);
    w_link_up_d   = (w_next_state == ACTIVE);
  end

  // Outputs are registered from next-state so they track r_state exactly.
  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_vsync_d   <= 1'b0;
      r_phy_reset <= 1'b1;
      r_link_up   <= 1'b0;
      r_lane_ch0  <= TMDS_CTRL_C0;
      r_lane_ch1  <= TMDS_CTRL_C0;
      r_lane_ch2  <= TMDS_CTRL_C0;
      r_loss_cnt  <= '0;
    end else begin
      r_vsync_d   <= enc_vsync;
      r_phy_reset <= w_phy_reset_d;
      r_link_up   <= w_link_up_d;
      r_lane_ch0  <= w_link_up_d ? enc_ch0 : TMDS_CTRL_C0;
      r_lane_ch1  <= w_link_up_d ? enc_ch1 : TMDS_CTRL_C0;
      r_lane_ch2  <= w_link_up_d ? enc_ch2 : TMDS_CTRL_C0;
      if (w_loss_evt && (r_loss_cnt != LOSS_CNT_MAX)) r_loss_cnt <= r_loss_cnt + 1'b1;
    end
  end

  assign lane_ch0      = r_lane_ch0;
  assign lane_ch1      = r_lane_ch1;
  assign lane_ch2      = r_lane_ch2;
  assign phy_reset     = r_phy_reset;
  assign link_up       = r_link_up;
  assign lock_loss_cnt = r_loss_cnt;

endmodule
`default_nettype wire
